ex_branch_resolve: RTL and testbench

Execute-stage control-flow resolver: the far end of the IF-stage early decode/predict path. It takes each control-flow instruction reaching EX with the prediction IF made for it. It computes the architecturally correct next PC and, on a mispredict, raises a held redirect request to the IF PC generator. It also owns the 16-entry 2-bit branch history table (BHT) that IF reads for conditional-branch direction prediction, and keeps a mispredict counter for performance monitoring.

---
 rtl/ex_branch_resolve.sv | 149 ++++++++++++++
 tb/tb_ex_branch_resolve.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_branch_resolve.sv
// ex_branch_resolve: execute-stage control-flow resolver.
// Computes the true next PC for JAL/JALR/branches, raises a held redirect to
// the IF PC generator on a mispredict, owns the 2-bit branch history table
// that IF reads, and counts resolved mispredicts.
module ex_branch_resolve #(
    parameter int XLEN      = 32,
    parameter int BHT_IDX_W = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            ex_valid_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic            ex_jal_i,
    input  logic            ex_jalr_i,
    input  logic            ex_branch_i,
    input  logic            ex_br_cond_i,
    input  logic [XLEN-1:0] ex_rs1_rdata_i,
    input  logic [XLEN-1:0] ex_imm_i,
    input  logic            ex_pred_taken_i,
    input  logic [XLEN-1:0] ex_pred_target_i,
    output logic            redirect_valid_o,
    input  logic            redirect_ready_i,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic [XLEN-1:0] link_addr_o,
    input  logic [XLEN-1:0] if_pc_i,
    output logic            if_bht_taken_o,
    output logic [31:0]     mispred_cnt_o
);

    localparam int BHT_N = 1 << BHT_IDX_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] redirect_pc_reg, redirect_pc_next;
    logic [31:0]     mispred_cnt_reg, mispred_cnt_next;
    logic [1:0]      bht_reg [BHT_N];

    logic            cf;
    logic            taken;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] correct_pc;
    logic            mispredict;
    logic            accept;

    logic [BHT_IDX_W-1:0] ex_idx;
    logic [BHT_IDX_W-1:0] if_idx;
    logic [1:0]           bht_cur;
    logic [1:0]           bht_upd;
    logic                 bht_we;

    // PC bits outside the BHT index field do not take part in the lookup.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc_i[XLEN-1:BHT_IDX_W+2], if_pc_i[1:0],
                              ex_pc_i[XLEN-1:BHT_IDX_W+2], ex_pc_i[1:0]};

    assign ex_idx = ex_pc_i[BHT_IDX_W+1:2];
    assign if_idx = if_pc_i[BHT_IDX_W+1:2];

    // Target, direction and mispredict evaluation for the instruction in EX.
    always_comb begin
        cf         = ex_jal_i | ex_jalr_i | ex_branch_i;
        pc_plus4   = ex_pc_i + XLEN'(4);
        br_target  = ex_pc_i + ex_imm_i;
        jalr_sum   = ex_rs1_rdata_i + ex_imm_i;
        target     = ex_jalr_i ? {jalr_sum[XLEN-1:1], 1'b0} : br_target;
        taken      = ex_jal_i | ex_jalr_i | ex_br_cond_i;
        correct_pc = taken ? target : pc_plus4;
        mispredict = (ex_pred_taken_i != taken) |
                     (taken & (ex_pred_target_i != target));
        // Anything in EX while a redirect is outstanding is wrong-path.
        accept     = ex_valid_i & cf & (state_reg == ST_IDLE);
    end

    assign link_addr_o      = pc_plus4;
    assign redirect_valid_o = (state_reg == ST_PEND);
    assign redirect_pc_o    = redirect_pc_reg;
    assign mispred_cnt_o    = mispred_cnt_reg;

    // Redirect FSM next-state: capture on accepted mispredict, hold until taken by IF.
    always_comb begin
        state_next       = state_reg;
        redirect_pc_next = redirect_pc_reg;
        mispred_cnt_next = mispred_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept && mispredict) begin
                    state_next       = ST_PEND;
                    redirect_pc_next = correct_pc;
                    mispred_cnt_next = mispred_cnt_reg + 32'd1;
                end
            end
            ST_PEND: begin
                if (redirect_ready_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Redirect FSM and counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_reg       <= ST_IDLE;
            redirect_pc_reg <= '0;
            mispred_cnt_reg <= '0;
        end else begin
            state_reg       <= state_next;
            redirect_pc_reg <= redirect_pc_next;
            mispred_cnt_reg <= mispred_cnt_next;
        end
    end

    // Saturating update value for the counter indexed by the resolving branch.
    always_comb begin
        bht_we  = accept & ex_branch_i;
        bht_cur = bht_reg[ex_idx];
        bht_upd = bht_cur;
        if (taken) begin
            if (bht_cur != 2'b11) bht_upd = bht_cur + 2'b01;
        end else begin
            if (bht_cur != 2'b00) bht_upd = bht_cur - 2'b01;
        end
    end

    // One counter register per BHT entry; reset to weakly not-taken.
    generate
        for (genvar gi = 0; gi < BHT_N; gi++) begin : g_bht
            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    bht_reg[gi] <= 2'b01;
                end else if (bht_we && (ex_idx == BHT_IDX_W'(gi))) begin
                    bht_reg[gi] <= bht_upd;
                end
            end
        end
    endgenerate

    // Prediction read is combinational, so a same-cycle update is not yet visible.
    assign if_bht_taken_o = bht_reg[if_idx][1];

endmodule

// File: tb/tb_ex_branch_resolve.sv
// Directed bench for ex_branch_resolve: redirects are checked by a monitor
// against a scoreboard queue; combinational outputs are checked inline.
module tb_ex_branch_resolve;

    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_n_i;
    logic            ex_valid_i;
    logic [XLEN-1:0] ex_pc_i;
    logic            ex_jal_i;
    logic            ex_jalr_i;
    logic            ex_branch_i;
    logic            ex_br_cond_i;
    logic [XLEN-1:0] ex_rs1_rdata_i;
    logic [XLEN-1:0] ex_imm_i;
    logic            ex_pred_taken_i;
    logic [XLEN-1:0] ex_pred_target_i;
    logic            redirect_valid_o;
    logic            redirect_ready_i;
    logic [XLEN-1:0] redirect_pc_o;
    logic [XLEN-1:0] link_addr_o;
    logic [XLEN-1:0] if_pc_i;
    logic            if_bht_taken_o;
    logic [31:0]     mispred_cnt_o;

    always #5 clk_i = ~clk_i;

    ex_branch_resolve #(.XLEN(XLEN), .BHT_IDX_W(4)) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .ex_valid_i       (ex_valid_i),
        .ex_pc_i          (ex_pc_i),
        .ex_jal_i         (ex_jal_i),
        .ex_jalr_i        (ex_jalr_i),
        .ex_branch_i      (ex_branch_i),
        .ex_br_cond_i     (ex_br_cond_i),
        .ex_rs1_rdata_i   (ex_rs1_rdata_i),
        .ex_imm_i         (ex_imm_i),
        .ex_pred_taken_i  (ex_pred_taken_i),
        .ex_pred_target_i (ex_pred_target_i),
        .redirect_valid_o (redirect_valid_o),
        .redirect_ready_i (redirect_ready_i),
        .redirect_pc_o    (redirect_pc_o),
        .link_addr_o      (link_addr_o),
        .if_pc_i          (if_pc_i),
        .if_bht_taken_o   (if_bht_taken_o),
        .mispred_cnt_o    (mispred_cnt_o)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_ex();
        ex_valid_i       = 1'b0;
        ex_jal_i         = 1'b0;
        ex_jalr_i        = 1'b0;
        ex_branch_i      = 1'b0;
        ex_br_cond_i     = 1'b0;
        ex_pc_i          = '0;
        ex_rs1_rdata_i   = '0;
        ex_imm_i         = '0;
        ex_pred_taken_i  = 1'b0;
        ex_pred_target_i = '0;
    endtask

    task automatic set_cf(input logic a_jal, input logic a_jalr, input logic a_br,
                          input logic a_cond, input logic [31:0] a_pc,
                          input logic [31:0] a_rs1, input logic [31:0] a_imm,
                          input logic a_ptaken, input logic [31:0] a_ptgt);
        ex_valid_i       = 1'b1;
        ex_jal_i         = a_jal;
        ex_jalr_i        = a_jalr;
        ex_branch_i      = a_br;
        ex_br_cond_i     = a_cond;
        ex_pc_i          = a_pc;
        ex_rs1_rdata_i   = a_rs1;
        ex_imm_i         = a_imm;
        ex_pred_taken_i  = a_ptaken;
        ex_pred_target_i = a_ptgt;
        $display("issue jal=%0b jalr=%0b br=%0b cond=%0b pc=0x%08h imm=0x%08h pred=%0b/0x%08h",
                 a_jal, a_jalr, a_br, a_cond, a_pc, a_imm, a_ptaken, a_ptgt);
    endtask

    // Monitor: pop on each new redirect, and require the PC to hold while pending.
    initial begin : monitor
        logic        prev_valid;
        logic [31:0] held_pc;
        exp_t        e;
        prev_valid = 1'b0;
        held_pc    = '0;
        forever begin
            @(negedge clk_i);
            if (redirect_valid_o && !prev_valid) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL redir_unexpected: got pc 0x%08h, expected no redirect", redirect_pc_o);
                end else begin
                    e = sb.pop_front();
                    check("redir_pc", redirect_pc_o, e.pc);
                    check("redir_cnt", mispred_cnt_o, e.cnt);
                end
                held_pc = redirect_pc_o;
                $display("redirect pc=0x%08h cnt=%0d", redirect_pc_o, mispred_cnt_o);
            end else if (redirect_valid_o && prev_valid) begin
                check("redir_hold", redirect_pc_o, held_pc);
            end
            prev_valid = redirect_valid_o;
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    logic bht_exp [6];

    initial begin
        rst_n_i          = 1'b0;
        redirect_ready_i = 1'b0;
        if_pc_i          = '0;
        idle_ex();
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;

        // Reset state and all BHT entries weakly not-taken.
        @(negedge clk_i);
        check("rst_valid", redirect_valid_o, 1'b0);
        check("rst_pc", redirect_pc_o, 32'h0);
        check("rst_cnt", mispred_cnt_o, 32'h0);
        for (int i = 0; i < 16; i++) begin
            if_pc_i = 32'(i) << 2;
            #1;
            check("rst_bht", if_bht_taken_o, 1'b0);
        end

        // Taken branch predicted not-taken: redirect to 0x140, stall 3 cycles.
        @(posedge clk_i); #1;
        set_cf(0, 0, 1, 1, 32'h100, 32'h0, 32'h40, 0, 32'h0);
        sb.push_back('{pc: 32'h140, cnt: 32'd1});
        @(posedge clk_i); #1;
        idle_ex();
        @(negedge clk_i);
        check("redir_latency", redirect_valid_o, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("redir_stall_valid", redirect_valid_o, 1'b1);
        end
        @(posedge clk_i); #1 redirect_ready_i = 1'b1;
        @(posedge clk_i); #1 redirect_ready_i = 1'b0;
        @(negedge clk_i);
        check("redir_done", redirect_valid_o, 1'b0);

        // Correctly predicted JALR (bit 0 cleared) and JAL with negative offset.
        @(posedge clk_i); #1;
        set_cf(0, 1, 0, 0, 32'h200, 32'h2003, 32'h10, 1, 32'h2012);
        @(negedge clk_i);
        check("jalr_link", link_addr_o, 32'h204);
        @(posedge clk_i); #1;
        set_cf(1, 0, 0, 0, 32'h400, 32'h0, 32'hFFFF_FFF0, 1, 32'h3F0);
        @(negedge clk_i);
        check("jal_link", link_addr_o, 32'h404);
        @(posedge clk_i); #1;
        idle_ex();
        @(negedge clk_i);
        check("jump_no_redir", redirect_valid_o, 1'b0);
        check("jump_cnt", mispred_cnt_o, 32'd1);

        // BHT at pc 0x8: taken x3 then not-taken x2; each check is the pre-update value.
        bht_exp[0] = 1'b0; bht_exp[1] = 1'b1; bht_exp[2] = 1'b1;
        bht_exp[3] = 1'b1; bht_exp[4] = 1'b1; bht_exp[5] = 1'b0;
        if_pc_i = 32'h8;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk_i); #1;
            if (k < 3)      set_cf(0, 0, 1, 1, 32'h8, 32'h0, 32'h20, 1, 32'h28);
            else if (k < 5) set_cf(0, 0, 1, 0, 32'h8, 32'h0, 32'h20, 0, 32'h0);
            else            idle_ex();
            @(negedge clk_i);
            check("bht_seq", if_bht_taken_o, bht_exp[k]);
        end
        check("bht_cnt", mispred_cnt_o, 32'd1);

        // Not-taken branch predicted taken -> 0x304; a second mispredict while pending is ignored.
        @(posedge clk_i); #1;
        set_cf(0, 0, 1, 0, 32'h300, 32'h0, 32'h10, 1, 32'h310);
        sb.push_back('{pc: 32'h304, cnt: 32'd2});
        @(posedge clk_i); #1;
        set_cf(0, 0, 1, 1, 32'h14, 32'h0, 32'h100, 0, 32'h0);
        if_pc_i = 32'h14;
        @(negedge clk_i);
        check("pend_valid", redirect_valid_o, 1'b1);
        @(negedge clk_i);
        @(negedge clk_i);
        check("pend_pc", redirect_pc_o, 32'h304);
        check("pend_cnt", mispred_cnt_o, 32'd2);
        check("pend_bht", if_bht_taken_o, 1'b0);
        @(posedge clk_i); #1 redirect_ready_i = 1'b1;
        @(posedge clk_i); #1;
        redirect_ready_i = 1'b0;
        idle_ex();
        @(negedge clk_i);
        check("ready_cycle_valid", redirect_valid_o, 1'b0);
        check("ready_cycle_cnt", mispred_cnt_o, 32'd2);
        check("ready_cycle_bht", if_bht_taken_o, 1'b0);

        // Mispredict at pc 0x108 (BHT index 2), then reset while pending.
        @(posedge clk_i); #1;
        set_cf(0, 0, 1, 1, 32'h108, 32'h0, 32'h40, 0, 32'h0);
        sb.push_back('{pc: 32'h148, cnt: 32'd3});
        if_pc_i = 32'h8;
        @(posedge clk_i); #1;
        idle_ex();
        @(negedge clk_i);
        check("pre_rst_valid", redirect_valid_o, 1'b1);
        check("pre_rst_bht", if_bht_taken_o, 1'b1);
        @(posedge clk_i); #1;
        rst_n_i          = 1'b0;
        redirect_ready_i = 1'b1;
        set_cf(0, 0, 1, 1, 32'h108, 32'h0, 32'h40, 0, 32'h0);
        @(posedge clk_i); #1;
        rst_n_i          = 1'b1;
        redirect_ready_i = 1'b0;
        idle_ex();
        @(negedge clk_i);
        check("pend_rst_valid", redirect_valid_o, 1'b0);
        check("pend_rst_pc", redirect_pc_o, 32'h0);
        check("pend_rst_cnt", mispred_cnt_o, 32'h0);
        check("pend_rst_bht", if_bht_taken_o, 1'b0);

        // One taken update after reset flips the prediction only if reset left 2'b01.
        @(posedge clk_i); #1;
        set_cf(0, 0, 1, 1, 32'h8, 32'h0, 32'h20, 1, 32'h28);
        @(posedge clk_i); #1;
        idle_ex();
        @(negedge clk_i);
        check("rst_weak_bht", if_bht_taken_o, 1'b1);
        check("rst_weak_cnt", mispred_cnt_o, 32'h0);

        @(negedge clk_i);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
